// File: rtl/myo_spi_pkg.sv
// Shared definitions for the myocontrol SPI bus: mode, word sizing, responder FSM states
// and the frame header layout used by both the master and the emulated motor boards.
package myo_spi_pkg;

   localparam int SPI_CPOL = 0;
   localparam int SPI_CPHA = 1;

   localparam int DEF_WORD_BITS = 16;
   localparam int DEF_MAX_WORDS = 12;

   // First word of every frame: write flag and target motor id
   localparam int HDR_WRITE_BIT    = 15;
   localparam int HDR_MOTOR_ID_MSB = 14;
   localparam int HDR_MOTOR_ID_LSB = 8;
   localparam int HDR_MOTOR_ID_W   = HDR_MOTOR_ID_MSB - HDR_MOTOR_ID_LSB + 1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } spi_state_t;

   function automatic logic hdr_is_write(input logic [DEF_WORD_BITS-1:0] hdr);
      return hdr[HDR_WRITE_BIT];
   endfunction

   function automatic logic [HDR_MOTOR_ID_W-1:0] hdr_motor_id(input logic [DEF_WORD_BITS-1:0] hdr);
      return hdr[HDR_MOTOR_ID_MSB:HDR_MOTOR_ID_LSB];
   endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Brings one asynchronous SPI pin into the clock domain: two metastability flops plus a
// history flop; rise/fall pulse for one cycle, three cycles after the pin moves.
module spi_input_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [2:0] sync_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q <= {3{RST_VAL}};
      end else begin
         sync_q <= {sync_q[1:0], din};
      end
   end

   assign dout = sync_q[1];
   assign rise = sync_q[1] & ~sync_q[2];
   assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/myo_spi_responder.sv
// SPI mode-1 slave emulating one myocontrol motor board: shifts multi-word frames in/out,
// reports words ~3 cycles after each sck edge; no backpressure, the master owns the pace.
module myo_spi_responder
   import myo_spi_pkg::*;
#(
   parameter int WORD_BITS = DEF_WORD_BITS,
   parameter int MAX_WORDS = DEF_MAX_WORDS,
   parameter int IDX_W     = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sck,
   input  logic                 ss_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   output logic [IDX_W-1:0]     tx_index,
   input  logic [WORD_BITS-1:0] tx_word,
   output logic                 tx_load,
   output logic                 rx_valid,
   output logic [WORD_BITS-1:0] rx_data,
   output logic [IDX_W-1:0]     rx_index,
   output logic                 frame_done,
   output logic [IDX_W:0]       frame_words,
   output logic                 frame_error
);

   localparam int BIT_W      = $clog2(WORD_BITS);
   localparam int LAST_BIT_I = WORD_BITS - 1;
   localparam int MAX_IDX_I  = MAX_WORDS - 1;

   localparam logic [BIT_W-1:0] LAST_BIT = LAST_BIT_I[BIT_W-1:0];
   localparam logic [IDX_W:0]   MAX_CNT  = MAX_WORDS[IDX_W:0];
   localparam logic [IDX_W-1:0] MAX_IDX  = MAX_IDX_I[IDX_W-1:0];

   // Mode 1 launches miso on the leading (rising) edge and captures mosi on the trailing one
   localparam bit LAUNCH_ON_RISE = ((SPI_CPOL == 0) == (SPI_CPHA == 1));

   logic sck_lvl_unused, ss_lvl_unused, mosi_s;
   logic sck_rise, sck_fall, ss_rise, ss_fall;
   logic [1:0] mosi_edge_unused;
   logic launch_edge, capture_edge;

   spi_input_sync #(.RST_VAL(1'b0)) u_sck_sync (
      .clock (clock),
      .reset (reset),
      .din   (sck),
      .dout  (sck_lvl_unused),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   spi_input_sync #(.RST_VAL(1'b1)) u_ss_sync (
      .clock (clock),
      .reset (reset),
      .din   (ss_n),
      .dout  (ss_lvl_unused),
      .rise  (ss_rise),
      .fall  (ss_fall)
   );

   spi_input_sync #(.RST_VAL(1'b0)) u_mosi_sync (
      .clock (clock),
      .reset (reset),
      .din   (mosi),
      .dout  (mosi_s),
      .rise  (mosi_edge_unused[0]),
      .fall  (mosi_edge_unused[1])
   );

   assign launch_edge  = LAUNCH_ON_RISE ? sck_rise : sck_fall;
   assign capture_edge = LAUNCH_ON_RISE ? sck_fall : sck_rise;

   function automatic logic [IDX_W-1:0] sat_idx(input logic [IDX_W:0] cnt);
      return (cnt >= MAX_CNT) ? MAX_IDX : cnt[IDX_W-1:0];
   endfunction

   spi_state_t            state_q, state_d;
   logic [WORD_BITS-1:0]  shift_tx_q, shift_tx_d;
   logic [WORD_BITS-2:0]  shift_rx_q, shift_rx_d;
   logic [WORD_BITS-1:0]  rx_word;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [IDX_W:0]        word_cnt_q, word_cnt_d, word_inc;
   logic                  overflow_q, overflow_d;

   logic                  miso_d, miso_oe_d, tx_load_d, rx_valid_d, frame_done_d, frame_error_d;
   logic [IDX_W-1:0]      tx_index_d, rx_index_d;
   logic [WORD_BITS-1:0]  rx_data_d;
   logic [IDX_W:0]        frame_words_d;

   assign rx_word  = {shift_rx_q, mosi_s};
   assign word_inc = word_cnt_q + {{IDX_W{1'b0}}, 1'b1};

   always_comb begin
      state_d       = state_q;
      shift_tx_d    = shift_tx_q;
      shift_rx_d    = shift_rx_q;
      bit_cnt_d     = bit_cnt_q;
      word_cnt_d    = word_cnt_q;
      overflow_d    = overflow_q;
      miso_d        = miso;
      miso_oe_d     = miso_oe;
      tx_index_d    = tx_index;
      tx_load_d     = 1'b0;
      rx_valid_d    = 1'b0;
      rx_data_d     = rx_data;
      rx_index_d    = rx_index;
      frame_done_d  = 1'b0;
      frame_words_d = frame_words;
      frame_error_d = 1'b0;

      // tx_word is presented for the index published on the previous cycle
      if (tx_load) begin
         shift_tx_d = overflow_q ? '0 : tx_word;
      end else if (state_q == ST_SHIFT && launch_edge) begin
         shift_tx_d = {shift_tx_q[WORD_BITS-2:0], 1'b0};
      end

      case (state_q)
         ST_IDLE: begin
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
            if (ss_fall) begin
               state_d    = ST_SHIFT;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
               overflow_d = 1'b0;
               tx_index_d = '0;
               tx_load_d  = 1'b1;
               miso_oe_d  = 1'b1;
            end
         end

         ST_SHIFT: begin
            if (launch_edge) begin
               miso_d = overflow_q ? 1'b0 : shift_tx_q[WORD_BITS-1];
            end

            if (capture_edge) begin
               shift_rx_d = rx_word[WORD_BITS-2:0];
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d  = '0;
                  rx_valid_d = 1'b1;
                  rx_data_d  = rx_word;
                  rx_index_d = sat_idx(word_cnt_q);
                  word_cnt_d = (word_cnt_q >= MAX_CNT) ? MAX_CNT : word_inc;
                  tx_index_d = sat_idx(word_inc);
                  tx_load_d  = 1'b1;
                  if (word_inc >= MAX_CNT) begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + {{(BIT_W-1){1'b0}}, 1'b1};
               end
            end

            // A word finishing on this same cycle is counted before the frame closes
            if (ss_rise) begin
               state_d       = ST_IDLE;
               miso_d        = 1'b0;
               miso_oe_d     = 1'b0;
               tx_load_d     = 1'b0;
               frame_done_d  = 1'b1;
               frame_words_d = word_cnt_d;
               frame_error_d = (bit_cnt_d != '0) | overflow_d;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shift_tx_q  <= '0;
         shift_rx_q  <= '0;
         bit_cnt_q   <= '0;
         word_cnt_q  <= '0;
         overflow_q  <= 1'b0;
         miso        <= 1'b0;
         miso_oe     <= 1'b0;
         tx_index    <= '0;
         tx_load     <= 1'b0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         rx_index    <= '0;
         frame_done  <= 1'b0;
         frame_words <= '0;
         frame_error <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_tx_q  <= shift_tx_d;
         shift_rx_q  <= shift_rx_d;
         bit_cnt_q   <= bit_cnt_d;
         word_cnt_q  <= word_cnt_d;
         overflow_q  <= overflow_d;
         miso        <= miso_d;
         miso_oe     <= miso_oe_d;
         tx_index    <= tx_index_d;
         tx_load     <= tx_load_d;
         rx_valid    <= rx_valid_d;
         rx_data     <= rx_data_d;
         rx_index    <= rx_index_d;
         frame_done  <= frame_done_d;
         frame_words <= frame_words_d;
         frame_error <= frame_error_d;
      end
   end

endmodule
